acc_bank: RTL and testbench



---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_bank_if.sv | 29 ++
 rtl/acc_serial_mul.sv | 67 ++++++
 rtl/acc_bank.sv | 157 +++++++++++++++
 tb/tb_acc_bank.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared constants for the accumulator bank: opcodes, flag bit positions
// and the MAC sequencer state encoding.
package acc_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_SHL  = 3'd4;
   localparam logic [2:0] OP_SHR  = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;
   localparam logic [2:0] OP_MAC  = 3'd7;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;

   typedef logic [3:0] flags_t;

endpackage

// File: rtl/acc_bank_if.sv
// Op-issue and read-port bundle between the control unit (master) and the
// accumulator bank (slave).
interface acc_bank_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 2
);
   import acc_pkg::*;

   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [SEL_W-1:0]  op_sel;
   logic [DATA_W-1:0] op_data;
   logic [SEL_W-1:0]  rd_sel;
   logic [DATA_W-1:0] rd_data;
   flags_t            rd_flags;
   logic              done;

   modport master (
      output op_valid, op_code, op_sel, op_data, rd_sel,
      input  op_ready, rd_data, rd_flags, done
   );

   modport slave (
      input  op_valid, op_code, op_sel, op_data, rd_sel,
      output op_ready, rd_data, rd_flags, done
   );

endinterface

// File: rtl/acc_serial_mul.sv
// Unsigned DATA_W/2 x DATA_W/2 shift-add multiplier, one partial product per clock.
// done_o is high during the cycle whose edge performs the last step; prod_o is final after it.
module acc_serial_mul #(
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [DATA_W/2-1:0] a_i,
   input  logic [DATA_W/2-1:0] b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [DATA_W-1:0]   prod_o
);
   localparam int HALF  = DATA_W / 2;
   localparam int CNT_W = $clog2(HALF + 1);

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] prod_q, prod_d;
   logic [HALF-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              last;

   assign last   = busy_q && (cnt_q == CNT_W'(1));
   assign busy_o = busy_q;
   assign done_o = last;
   assign prod_o = prod_q;

   always_comb begin
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start_i && !busy_q) begin
         mcand_d  = {{HALF{1'b0}}, a_i};
         mplier_d = b_i;
         prod_d   = '0;
         cnt_d    = CNT_W'(HALF);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) prod_d = prod_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CNT_W'(1);
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with per-accumulator {Z,N,C,V} flags,
// single-cycle ALU ops and a serial multiply-accumulate.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting ops; single-cycle ops commit on their accept edge
// MUL     | serial multiplier stepping, op_ready low
// WB      | add product into the latched accumulator, then back to IDLE
module acc_bank
   import acc_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int NUM_ACC = 4,
   parameter int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
   input  logic     clk,
   input  logic     rst,
   acc_bank_if.slave bus
);
   localparam int HALF = DATA_W / 2;
   localparam int MSB  = DATA_W - 1;

   logic [DATA_W-1:0] acc_q [NUM_ACC];
   flags_t            flg_q [NUM_ACC];
   logic [1:0]        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              done_q;

   logic              accept, mac_start, in_wb;
   logic              mul_busy, mul_done;
   logic [DATA_W-1:0] mul_prod;

   logic [2:0]        c_code;
   logic [SEL_W-1:0]  c_sel;
   logic [DATA_W-1:0] c_opnd, cur, res;
   logic              sel_ok, c_flag, v_flag, commit_en;
   logic [DATA_W:0]   sum, diff;
   flags_t            res_flg;

   assign accept       = bus.op_valid && bus.op_ready;
   assign mac_start    = accept && (bus.op_code == OP_MAC);
   assign in_wb        = (state_q == ST_WB);
   assign bus.op_ready = (state_q == ST_IDLE) && !mul_busy;
   assign bus.done     = done_q;

   acc_serial_mul #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (mac_start),
      .a_i     (bus.op_data[HALF-1:0]),
      .b_i     (bus.op_data[DATA_W-1:HALF]),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: if (mac_start) begin
            state_d = ST_MUL;
            sel_d   = bus.op_sel;
         end
         ST_MUL:  if (mul_done) state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The MAC write-back reuses the ADD path with the product as operand.
   always_comb begin
      c_code = in_wb ? OP_ADD   : bus.op_code;
      c_sel  = in_wb ? sel_q    : bus.op_sel;
      c_opnd = in_wb ? mul_prod : bus.op_data;
      cur    = '0;
      sel_ok = 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
         if (c_sel == SEL_W'(i)) begin
            cur    = acc_q[i];
            sel_ok = 1'b1;
         end
      end
   end

   always_comb begin
      sum    = {1'b0, cur} + {1'b0, c_opnd};
      diff   = {1'b0, cur} - {1'b0, c_opnd};
      res    = cur;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (c_code)
         OP_LOAD: res = c_opnd;
         OP_ADD, OP_MAC: begin
            res    = sum[MSB:0];
            c_flag = sum[DATA_W];
            v_flag = (cur[MSB] == c_opnd[MSB]) && (res[MSB] != cur[MSB]);
         end
         OP_SUB: begin
            res    = diff[MSB:0];
            c_flag = diff[DATA_W];
            v_flag = (cur[MSB] != c_opnd[MSB]) && (res[MSB] != cur[MSB]);
         end
         OP_SHL: begin
            res    = {cur[MSB-1:0], 1'b0};
            c_flag = cur[MSB];
         end
         OP_SHR: begin
            res    = {1'b0, cur[MSB:1]};
            c_flag = cur[0];
         end
         OP_CLR:  res = '0;
         default: res = cur;
      endcase
      res_flg        = '0;
      res_flg[FLG_Z] = (res == '0);
      res_flg[FLG_N] = res[MSB];
      res_flg[FLG_C] = c_flag;
      res_flg[FLG_V] = v_flag;
      commit_en = sel_ok && (in_wb ||
                  (accept && (c_code != OP_NOP) && (c_code != OP_MAC)));
   end

   always_comb begin
      bus.rd_data  = '0;
      bus.rd_flags = '0;
      for (int i = 0; i < NUM_ACC; i++) begin
         if (bus.rd_sel == SEL_W'(i)) begin
            bus.rd_data  = acc_q[i];
            bus.rd_flags = flg_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NUM_ACC; i++) begin
            acc_q[i] <= '0;
            flg_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         done_q  <= commit_en;
         for (int i = 0; i < NUM_ACC; i++) begin
            if (commit_en && (c_sel == SEL_W'(i))) begin
               acc_q[i] <= res;
               flg_q[i] <= res_flg;
            end
         end
      end
   end

endmodule

// File: tb/tb_acc_bank.sv
// Directed plus randomized checks of acc_bank (NUM_ACC=4 and NUM_ACC=3 builds)
// against an arithmetic reference model of the accumulator rules.
module tb_acc_bank;
   import acc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   m_acc [4];
   int   m_flg [4];

   always #10 clk = ~clk;

   acc_bank_if #(.DATA_W(16), .SEL_W(2)) bus4 ();
   acc_bank_if #(.DATA_W(16), .SEL_W(2)) bus3 ();

   acc_bank #(.DATA_W(16), .NUM_ACC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   acc_bank #(.DATA_W(16), .NUM_ACC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   initial begin
      #5000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int sgn(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   function automatic void model_op(input int code, input int a, input int d,
                                    output int r, output int f);
      int c, v, s, p;
      c = 0; v = 0; r = a;
      case (code)
         1: r = d;
         2, 7: begin
            p = (code == 7) ? (d % 256) * (d / 256) : d;
            s = a + p;
            r = s % 65536;
            c = (s > 65535) ? 1 : 0;
            s = sgn(a) + sgn(p);
            v = (s > 32767 || s < -32768) ? 1 : 0;
         end
         3: begin
            r = (a - d + 65536) % 65536;
            c = (a < d) ? 1 : 0;
            s = sgn(a) - sgn(d);
            v = (s > 32767 || s < -32768) ? 1 : 0;
         end
         4: begin r = (a * 2) % 65536; c = (a >= 32768) ? 1 : 0; end
         5: begin r = a / 2; c = a % 2; end
         6: r = 0;
         default: r = a;
      endcase
      f = ((r == 0) ? 8 : 0) + ((r >= 32768) ? 4 : 0) + c * 2 + v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 4; i++) begin
         bus4.rd_sel = 2'(i);
         #1;
         chk($sformatf("%s_rd%0d", tag, i), 32'(bus4.rd_data), m_acc[i]);
         chk($sformatf("%s_flg%0d", tag, i), 32'(bus4.rd_flags), m_flg[i]);
      end
   endtask

   task automatic do_op(input int code, input int sel, input int data);
      int r, f;
      bus4.op_valid = 1'b1;
      bus4.op_code  = 3'(code);
      bus4.op_sel   = 2'(sel);
      bus4.op_data  = 16'(data);
      bus4.rd_sel   = 2'(sel);
      tick();
      if (code != 0) begin
         model_op(code, m_acc[sel], data, r, f);
         m_acc[sel] = r;
         m_flg[sel] = f;
      end
      chk($sformatf("op%0d_done", code), 32'(bus4.done), (code != 0) ? 1 : 0);
      chk($sformatf("op%0d_rd", code), 32'(bus4.rd_data), m_acc[sel]);
      chk($sformatf("op%0d_flg", code), 32'(bus4.rd_flags), m_flg[sel]);
      chk($sformatf("op%0d_ready", code), 32'(bus4.op_ready), 1);
   endtask

   task automatic do_mac(input int sel, input int data, input bit junk);
      int r, f, old;
      bus4.op_valid = 1'b1;
      bus4.op_code  = OP_MAC;
      bus4.op_sel   = 2'(sel);
      bus4.op_data  = 16'(data);
      bus4.rd_sel   = 2'(sel);
      tick();
      old = m_acc[sel];
      model_op(7, old, data, r, f);
      bus4.op_valid = junk;
      bus4.op_code  = OP_LOAD;
      bus4.op_data  = 16'hDEAD;
      for (int k = 0; k < 9; k++) begin
         chk("mac_ready_low", 32'(bus4.op_ready), 0);
         chk("mac_no_done", 32'(bus4.done), 0);
         chk("mac_hold", 32'(bus4.rd_data), old);
         tick();
      end
      m_acc[sel] = r;
      m_flg[sel] = f;
      chk("mac_done", 32'(bus4.done), 1);
      chk("mac_ready", 32'(bus4.op_ready), 1);
      chk("mac_rd", 32'(bus4.rd_data), r);
      chk("mac_flg", 32'(bus4.rd_flags), f);
      bus4.op_valid = 1'b0;
      tick();
      chk("mac_done_pulse", 32'(bus4.done), 0);
   endtask

   initial begin
      int code, sel, data, pick;
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_flg[i] = 0; end
      bus4.op_valid = 1'b0; bus4.op_code = '0; bus4.op_sel = '0;
      bus4.op_data  = '0;   bus4.rd_sel  = '0;
      bus3.op_valid = 1'b0; bus3.op_code = '0; bus3.op_sel = '0;
      bus3.op_data  = '0;   bus3.rd_sel  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus4.op_ready), 1);
      chk("rst_done", 32'(bus4.done), 0);
      check_all("rst");
      @(negedge clk) rst = 1'b0;
      tick();
      chk("post_rst_done", 32'(bus4.done), 0);
      chk("post_rst_ready", 32'(bus4.op_ready), 1);

      do_op(1, 1, 16'h7FFF);
      do_op(2, 1, 16'h0001);
      chk("add_val", 32'(bus4.rd_data), 32'h8000);
      chk("add_flg", 32'(bus4.rd_flags), 32'h5);
      do_op(6, 2, 16'h1234);
      do_op(3, 2, 16'h0001);
      chk("sub_val", 32'(bus4.rd_data), 32'hFFFF);
      chk("sub_flg", 32'(bus4.rd_flags), 32'h6);
      do_op(1, 0, 16'h8001);
      do_op(4, 0, 0);
      chk("shl_val", 32'(bus4.rd_data), 32'h0002);
      chk("shl_flg", 32'(bus4.rd_flags), 32'h2);
      do_op(5, 0, 0);
      chk("shr_val", 32'(bus4.rd_data), 32'h0001);
      chk("shr_flg", 32'(bus4.rd_flags), 32'h0);
      do_op(0, 0, 16'hBEEF);
      bus4.op_valid = 1'b0;
      tick();
      chk("idle_done", 32'(bus4.done), 0);

      do_op(1, 3, 16'h0010);
      do_mac(3, 16'h0C05, 1'b1);
      bus4.rd_sel = 2'd3;
      #1;
      chk("mac_val", 32'(bus4.rd_data), 32'h004C);
      check_all("mac");

      // Reset in the middle of a MAC: everything clears at once, no commit.
      bus4.op_valid = 1'b1; bus4.op_code = OP_MAC; bus4.op_sel = 2'd3;
      bus4.op_data = 16'hFFFF; bus4.rd_sel = 2'd3;
      tick();
      bus4.op_valid = 1'b0;
      repeat (3) tick();
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_flg[i] = 0; end
      chk("async_rst_rd", 32'(bus4.rd_data), 0);
      chk("async_rst_ready", 32'(bus4.op_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("abort_no_done", 32'(bus4.done), 0);
      end
      check_all("abort");
      do_op(1, 0, 16'hA5A5);

      // Three-accumulator build: index 3 does not exist.
      bus3.op_valid = 1'b1; bus3.op_code = OP_LOAD; bus3.op_sel = 2'd2;
      bus3.op_data = 16'h1234; bus3.rd_sel = 2'd2;
      tick();
      chk("n3_load_done", 32'(bus3.done), 1);
      chk("n3_load_rd", 32'(bus3.rd_data), 32'h1234);
      bus3.op_sel = 2'd3; bus3.op_data = 16'h5555; bus3.rd_sel = 2'd3;
      tick();
      bus3.op_valid = 1'b0;
      chk("n3_oor_done", 32'(bus3.done), 0);
      chk("n3_oor_rd", 32'(bus3.rd_data), 0);
      chk("n3_oor_flg", 32'(bus3.rd_flags), 0);
      bus3.rd_sel = 2'd2;
      #1;
      chk("n3_keep_rd", 32'(bus3.rd_data), 32'h1234);

      for (int n = 0; n < 150; n++) begin
         code = int'($urandom_range(0, 7));
         sel  = int'($urandom_range(0, 3));
         pick = int'($urandom_range(0, 7));
         case (pick)
            0: data = 16'h0000;
            1: data = 16'h0001;
            2: data = 16'h7FFF;
            3: data = 16'h8000;
            4: data = 16'hFFFF;
            default: data = int'($urandom_range(0, 65535));
         endcase
         if (code == 7) do_mac(sel, data, 1'($urandom_range(0, 1)));
         else           do_op(code, sel, data);
         if (n % 25 == 24) check_all("rand");
      end
      bus4.op_valid = 1'b0;
      tick();
      check_all("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
